// File: rtl/seq_step_tracker.sv
// Programmable input-sequence tracker. It steps through a loaded table of
// {level, channel} entries and reports done, or an error with a code.
module seq_step_tracker #(
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int TMO_W = 16,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   din,
    input  logic             start,
    input  logic             abort,
    input  logic             strict,
    input  logic [TMO_W-1:0] timeout,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [CW:0]      prog_data,
    input  logic [AW:0]      prog_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [AW-1:0]    step
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CW:0] NCH_V     = (CW+1)'(NCH);
    localparam logic [AW:0] DEPTH_V   = (AW+1)'(DEPTH);
    localparam logic [1:0]  CODE_NONE = 2'd0;
    localparam logic [1:0]  CODE_TMO  = 2'd1;
    localparam logic [1:0]  CODE_STR  = 2'd2;
    localparam logic [1:0]  CODE_PROG = 2'd3;

    state_t           r_state;
    logic [CW:0]      r_table [DEPTH];
    logic [NCH-1:0]   r_dinQ;
    logic [NCH-1:0]   r_dinQ2;
    logic [AW:0]      r_len;
    logic [TMO_W-1:0] r_cnt;
    logic             r_first;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_errCode;
    logic [AW-1:0]    r_step;

    logic [CW:0]      w_entry;
    logic [CW-1:0]    w_chan;
    logic [NCH-1:0]   w_chanMask;
    logic             w_level;
    logic             w_chanBad;
    logic             w_match;
    logic             w_strictViol;
    logic             w_timedOut;
    logic             w_lastStep;
    logic             w_progBad;
    logic             w_cntSat;

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_errCode;
    assign step     = r_step;

    // The table is frozen while a sequence is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (prog_we && (r_state != S_RUN)) begin
            r_table[prog_addr] <= prog_data;
        end
    end

    assign w_entry = r_table[r_step];
    assign w_chan  = w_entry[CW-1:0];

    always_comb begin
        w_chanMask = '0;
        w_level    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_chan == CW'(i)) begin
                w_chanMask[i] = 1'b1;
                w_level       = r_dinQ[i];
            end
        end
    end

    // The awaited channel is masked out, so a wrong-level toggle on it only waits.
    assign w_chanBad    = ({1'b0, w_chan} >= NCH_V);
    assign w_match      = (w_level == w_entry[CW]);
    assign w_strictViol = strict && !r_first && (|((r_dinQ ^ r_dinQ2) & ~w_chanMask));
    assign w_timedOut   = (timeout != '0) && (r_cnt == (timeout - TMO_W'(1)));
    assign w_lastStep   = ({1'b0, r_step} == (r_len - (AW+1)'(1)));
    assign w_progBad    = (prog_len == '0) || (prog_len > DEPTH_V);
    assign w_cntSat     = &r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_dinQ    <= '0;
            r_dinQ2   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= CODE_NONE;
            r_step    <= '0;
        end else begin
            r_dinQ  <= din;
            r_dinQ2 <= r_dinQ;
            if (abort) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_first   <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_errCode <= CODE_NONE;
                r_step    <= '0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_first <= 1'b0;
                        if (w_chanBad) begin
                            r_state   <= S_ERR;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                            r_errCode <= CODE_PROG;
                        end else if (w_match) begin
                            if (w_lastStep) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_step <= r_step + AW'(1);
                                r_cnt  <= '0;
                            end
                        end else if (w_strictViol) begin
                            r_state   <= S_ERR;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                            r_errCode <= CODE_STR;
                        end else if (w_timedOut) begin
                            r_state   <= S_ERR;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                            r_errCode <= CODE_TMO;
                        end else if (!w_cntSat) begin
                            r_cnt <= r_cnt + TMO_W'(1);
                        end
                    end
                    default: begin
                        if (start) begin
                            if (w_progBad) begin
                                r_state   <= S_ERR;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b0;
                                r_err     <= 1'b1;
                                r_errCode <= CODE_PROG;
                            end else begin
                                r_state   <= S_RUN;
                                r_len     <= prog_len;
                                r_step    <= '0;
                                r_cnt     <= '0;
                                r_first   <= 1'b1;
                                r_busy    <= 1'b1;
                                r_done    <= 1'b0;
                                r_err     <= 1'b0;
                                r_errCode <= CODE_NONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
